// File: rtl/dsp_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_ctrl
// Brief    : Sequences one DSP48A1 slice as a multiply-accumulate engine.
// Revision : 1.0  initial release
// ============================================================================
module dsp_mac_ctrl #(
  parameter int LEN_W     = 8,
  parameter int PIPE_LAT  = 3,
  parameter int OPMODEREG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_rstp,
  output logic             busy,
  output logic             done
);

  localparam int         C_OPM_DEPTH = PIPE_LAT - OPMODEREG;
  // The first flag only has to travel as far as the stage that feeds the OPMODE register.
  localparam int         C_F_DEPTH   = (C_OPM_DEPTH > 1) ? C_OPM_DEPTH - 1 : 1;
  localparam logic [7:0] C_OPM_LOAD  = 8'h01;
  localparam logic [7:0] C_OPM_ACC   = 8'h09;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_CLR   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_count;
  logic               r_first;
  logic [PIPE_LAT:1]  r_tag_v;
  logic [C_F_DEPTH:1] r_tag_f;
  logic               r_abort_clr;
  logic [7:0]         r_opmode;

  logic w_job_acc;
  logic w_beat_acc;
  logic w_active;
  logic w_abort;
  logic w_inflight;
  logic w_opm_v;
  logic w_opm_f;

  assign w_inflight = |r_tag_v[PIPE_LAT-1:1];

  // Tag that will occupy the OPMODE-aligned depth after this edge.
  generate
    if (C_OPM_DEPTH == 1) begin : g_opm_src_in
      assign w_opm_v = w_beat_acc;
      assign w_opm_f = r_first;
    end else begin : g_opm_src_pipe
      assign w_opm_v = r_tag_v[C_OPM_DEPTH-1];
      assign w_opm_f = r_tag_f[C_OPM_DEPTH-1];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    op_ready    = 1'b0;
    w_active    = 1'b0;
    w_job_acc   = 1'b0;
    w_beat_acc  = 1'b0;
    w_abort     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    dsp_rstp    = r_abort_clr;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        w_job_acc   = start_valid;
        if (start_valid)
          w_state_nxt = (len == '0) ? S_CLR : S_RUN;
      end
      S_RUN: begin
        op_ready   = 1'b1;
        w_active   = 1'b1;
        w_beat_acc = op_valid;
        w_abort    = abort;
        if (abort)
          w_state_nxt = S_IDLE;
        else if (op_valid && (r_count == LEN_W'(1)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_active = 1'b1;
        w_abort  = abort;
        if (abort)
          w_state_nxt = S_IDLE;
        else if (!w_inflight)
          w_state_nxt = S_DONE;
      end
      S_CLR: begin
        dsp_rstp    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dsp_cea    = w_beat_acc;
  assign dsp_ceb    = w_beat_acc;
  assign dsp_cem    = w_active;
  assign dsp_cep    = r_tag_v[PIPE_LAT];
  assign dsp_opmode = r_opmode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_first     <= 1'b0;
      r_tag_v     <= '0;
      r_tag_f     <= '0;
      r_abort_clr <= 1'b0;
      r_opmode    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_abort_clr <= w_abort;

      if (w_job_acc) begin
        r_count <= len;
        r_first <= 1'b1;
      end else if (w_beat_acc) begin
        r_count <= r_count - 1'b1;
        r_first <= 1'b0;
      end

      // Bubbles enter as invalid tags so P stays put while M keeps running.
      if (w_active && !w_abort) begin
        r_tag_v[1] <= w_beat_acc;
        r_tag_f[1] <= w_beat_acc & r_first;
        for (int k = 2; k <= PIPE_LAT; k++)
          r_tag_v[k] <= r_tag_v[k-1];
        for (int k = 2; k <= C_F_DEPTH; k++)
          r_tag_f[k] <= r_tag_f[k-1];
      end else begin
        r_tag_v <= '0;
        r_tag_f <= '0;
      end

      if (w_active && w_opm_v)
        r_opmode <= w_opm_f ? C_OPM_LOAD : C_OPM_ACC;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_ctrl
// Brief    : Self-checking bench for dsp_mac_ctrl with a behavioural slice model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_ctrl;

  localparam int LEN_W     = 8;
  localparam int PIPE_LAT  = 3;
  localparam int OPMODEREG = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] len_i;
  logic             abort;
  logic             op_valid;
  logic             op_ready;
  logic             dsp_cea;
  logic             dsp_ceb;
  logic             dsp_cem;
  logic             dsp_cep;
  logic [7:0]       dsp_opmode;
  logic             dsp_rstp;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  dsp_mac_ctrl #(
    .LEN_W     (LEN_W),
    .PIPE_LAT  (PIPE_LAT),
    .OPMODEREG (OPMODEREG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .len         (len_i),
    .abort       (abort),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .dsp_cea     (dsp_cea),
    .dsp_ceb     (dsp_ceb),
    .dsp_cem     (dsp_cem),
    .dsp_cep     (dsp_cep),
    .dsp_opmode  (dsp_opmode),
    .dsp_rstp    (dsp_rstp),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int  t;
    logic first;
  } beat_t;

  typedef struct {
    int len;
    int stall_mask;
    int exp_cep;
    int exp_rstp;
    int exp_gap;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         n_cep    = 0;
  int         n_rstp   = 0;
  int         n_done   = 0;
  logic       first_pending = 1'b0;
  beat_t      acc_q[$];
  longint     sb_q[$];
  longint     stg[1:PIPE_LAT];
  longint     p_reg    = 0;
  logic [7:0] opm_reg  = 8'h00;
  logic [7:0] op_a     = 8'h00;
  logic [7:0] op_b     = 8'h00;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes one cycle: beat/cep timing, opmode at P capture, sum at done, then advances the slice model.
  task automatic monitor();
    logic [7:0] opm_eff;
    beat_t      b;
    if (!rst) begin
      acc_q.delete();
      first_pending = 1'b0;
      return;
    end
    chk("ceb_eq_cea", dsp_ceb, dsp_cea);
    if (start_valid && start_ready) first_pending = 1'b1;
    if (dsp_cea) begin
      acc_q.push_back('{cyc, first_pending});
      first_pending = 1'b0;
    end
    opm_eff = (OPMODEREG != 0) ? opm_reg : dsp_opmode;
    if (dsp_cep) begin
      n_cep++;
      if (acc_q.size() == 0) begin
        chk("spurious_cep", 1, 0);
      end else begin
        b = acc_q.pop_front();
        chk("cep_time", cyc, b.t + PIPE_LAT);
        chk("opmode_at_cep", opm_eff, b.first ? 8'h01 : 8'h09);
      end
    end
    if (dsp_rstp) n_rstp++;
    if (done) begin
      n_done++;
      if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("p_at_done", p_reg, sb_q.pop_front());
    end
    if (dsp_rstp) p_reg = 0;
    else if (dsp_cep) p_reg = ((opm_eff == 8'h09) ? p_reg : 0) + stg[PIPE_LAT];
    if (dsp_cem)
      for (int k = PIPE_LAT; k >= 2; k--) stg[k] = stg[k-1];
    if (dsp_cea) stg[1] = longint'(op_a) * longint'(op_b);
    opm_reg = dsp_opmode;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_op_ready"},    op_ready,    0);
    chk({tag, "_cea"},         dsp_cea,     0);
    chk({tag, "_cem"},         dsp_cem,     0);
    chk({tag, "_cep"},         dsp_cep,     0);
    chk({tag, "_opmode"},      dsp_opmode,  0);
    chk({tag, "_rstp"},        dsp_rstp,    0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_done"},        done,        0);
  endtask

  // Runs one job to completion; returns in the cycle after done.
  task automatic run_job(input vec_t v);
    longint sum;
    int     waited;
    int     s_cyc;
    int     last_cyc;
    int     nc0;
    int     nr0;
    sum         = 0;
    start_valid = 1'b1;
    len_i       = v.len[LEN_W-1:0];
    waited      = 0;
    while (!start_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("start_wait", waited, 0);
    s_cyc = cyc;
    nc0   = n_cep;
    nr0   = n_rstp;
    tick();
    start_valid = 1'b0;
    last_cyc    = s_cyc;
    for (int i = 0; i < v.len; i++) begin
      if (i < 32 && v.stall_mask[i]) begin
        op_valid = 1'b0;
        tick();
      end
      op_valid = 1'b1;
      op_a     = 8'($urandom_range(0, 255));
      op_b     = 8'($urandom_range(0, 255));
      sum     += longint'(op_a) * longint'(op_b);
      last_cyc = cyc;
      tick();
    end
    op_valid = 1'b0;
    sb_q.push_back(sum);
    waited = 0;
    while (!done && waited < 100) begin
      tick();
      waited++;
    end
    chk("done_seen", done, 1);
    chk("done_gap", cyc - last_cyc, v.exp_gap);
    chk("cep_count", n_cep - nc0, v.exp_cep);
    chk("rstp_count", n_rstp - nr0, v.exp_rstp);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_after_done", start_ready, 1);
  endtask

  vec_t vecs[7];
  int   nd0;
  int   nc0;

  initial begin
    for (int k = 1; k <= PIPE_LAT; k++) stg[k] = 0;
    vecs[0] = '{4,   0,        4,   0, PIPE_LAT + 1};
    vecs[1] = '{3,   32'b010,  3,   0, PIPE_LAT + 1};
    vecs[2] = '{0,   0,        0,   1, 2};
    vecs[3] = '{1,   0,        1,   0, PIPE_LAT + 1};
    vecs[4] = '{5,   32'b10101, 5,  0, PIPE_LAT + 1};
    vecs[5] = '{16,  32'h8001, 16,  0, PIPE_LAT + 1};
    vecs[6] = '{255, 0,        255, 0, PIPE_LAT + 1};

    rst         = 1'b0;
    start_valid = 1'b0;
    abort       = 1'b0;
    op_valid    = 1'b0;
    len_i       = '0;
    @(posedge clk);
    #1;
    tick();
    chk_reset("in_reset");
    tick();
    rst = 1'b1;
    tick();
    chk_reset("after_reset");

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_rstp", dsp_rstp, 0);

    foreach (vecs[i]) run_job(vecs[i]);

    // Abort in DRAIN with two tags still in flight.
    start_valid = 1'b1;
    len_i       = 8'd4;
    tick();
    start_valid = 1'b0;
    op_valid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_a = 8'($urandom_range(0, 255));
      op_b = 8'($urandom_range(0, 255));
      tick();
    end
    op_valid = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_op_ready", op_ready, 0);
    chk("drain_cem", dsp_cem, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    acc_q.delete();
    nd0 = n_done;
    nc0 = n_cep;
    chk("abort_rstp", dsp_rstp, 1);
    chk("abort_start_ready", start_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cep", dsp_cep, 0);
    tick();
    chk("abort_rstp_pulse", dsp_rstp, 0);
    repeat (6) tick();
    chk("abort_no_done", n_done - nd0, 0);
    chk("abort_no_cep", n_cep - nc0, 0);

    // Reset asserted in the middle of RUN.
    start_valid = 1'b1;
    len_i       = 8'd4;
    tick();
    start_valid = 1'b0;
    op_valid    = 1'b1;
    tick();
    tick();
    chk("midrun_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("rst_mid_run");
    op_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    run_job('{1, 0, 1, 0, PIPE_LAT + 1});

    // Back-to-back single-term jobs, each started the cycle after done.
    for (int j = 0; j < 5; j++) run_job('{1, 0, 1, 0, PIPE_LAT + 1});

    tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("beat_q_empty", acc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
